// File: rtl/branch_redirect_arb_pkg.sv
// Shared core widths and the redirect record carried from the branch units to fetch.
package branch_redirect_arb_pkg;

    localparam int CORE_RV       = 64;
    localparam int CORE_NCOMMIT  = 32;
    localparam int CORE_LNCOMMIT = 5;
    localparam int CORE_BDEC     = 4;

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } arb_state_e;

    typedef struct packed {
        logic [CORE_RV-2:0]       pc;
        logic [CORE_LNCOMMIT-1:0] addr;
        logic                     is_short;
        logic [CORE_BDEC-2:0]     dec;
    } redirect_t;

endpackage

// File: rtl/branch_redirect_arb_if.sv
// Redirect handshake towards fetch: arbiter drives the held record, fetch acks it.
interface branch_redirect_arb_if
    import branch_redirect_arb_pkg::*;
#(
    parameter int RV       = CORE_RV,
    parameter int LNCOMMIT = CORE_LNCOMMIT,
    parameter int BDEC     = CORE_BDEC
);
    logic                redirect_valid;
    logic                redirect_ack;
    logic [RV-2:0]       redirect_pc;
    logic [LNCOMMIT-1:0] redirect_addr;
    logic                redirect_short;
    logic [BDEC-2:0]     redirect_dec;

    modport master (
        output redirect_valid, redirect_pc, redirect_addr, redirect_short, redirect_dec,
        input  redirect_ack
    );

    modport slave (
        input  redirect_valid, redirect_pc, redirect_addr, redirect_short, redirect_dec,
        output redirect_ack
    );
endinterface

// File: rtl/branch_redirect_arb_age_cmp.sv
// Commit-slot age comparator: a_older is set when slot a is strictly older than slot b.
module commit_age_cmp #(
    parameter int N  = 32,
    parameter int LN = 5
) (
    input  logic [LN-1:0] a,
    input  logic [LN-1:0] b,
    input  logic [LN-1:0] head,
    output logic          a_older
);
    localparam logic [LN:0] NW = (LN+1)'(N);

    logic [LN:0] age_a, age_b;

    // Age is distance from head modulo N, so slots behind head wrap to the young end.
    assign age_a = (a >= head) ? ({1'b0, a} - {1'b0, head}) : ({1'b0, a} + NW - {1'b0, head});
    assign age_b = (b >= head) ? ({1'b0, b} - {1'b0, head}) : ({1'b0, b} + NW - {1'b0, head});
    assign a_older = age_a < age_b;
endmodule

// File: rtl/branch_redirect_arb.sv
// Picks the oldest live mispredict redirect among the branch units and holds it until fetch acks.
module branch_redirect_arb
    import branch_redirect_arb_pkg::*;
#(
    parameter int RV       = CORE_RV,
    parameter int NBR      = 2,
    parameter int NCOMMIT  = CORE_NCOMMIT,
    parameter int LNCOMMIT = CORE_LNCOMMIT,
    parameter int BDEC     = CORE_BDEC
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NBR-1:0]                br_enable,
    input  logic [NBR-1:0][LNCOMMIT-1:0]  br_addr,
    input  logic [NBR-1:0][RV-2:0]        br_dest,
    input  logic [NBR-1:0]                br_short,
    input  logic [NBR-1:0][BDEC-2:0]      br_dec,
    input  logic [LNCOMMIT-1:0]           commit_head,
    input  logic [NCOMMIT-1:0]            commit_kill,
    branch_redirect_arb_if.master         rd,
    output logic [7:0]                    drop_count
);
    arb_state_e state;
    logic       valid_q;
    redirect_t  hold;

    logic [NBR-1:0]          cand, win;
    logic [NBR-1:0][NBR-1:0] older;
    logic                    win_any, multi, win_older_held, kill_held, drop_now;
    redirect_t               win_rec;

    always_comb begin
        for (int i = 0; i < NBR; i++) cand[i] = br_enable[i] & ~commit_kill[br_addr[i]];
    end

    // older[i][j]: unit i's slot is strictly older than unit j's slot
    for (genvar gi = 0; gi < NBR; gi++) begin : g_row
        for (genvar gj = 0; gj < NBR; gj++) begin : g_col
            if (gi == gj) begin : g_diag
                assign older[gi][gj] = 1'b0;
            end else begin : g_cmp
                commit_age_cmp #(.N(NCOMMIT), .LN(LNCOMMIT)) u_cmp (
                    .a       (br_addr[gi]),
                    .b       (br_addr[gj]),
                    .head    (commit_head),
                    .a_older (older[gi][gj])
                );
            end
        end
    end

    // A lower-index unit wins ties; a higher-index unit must be strictly older.
    always_comb begin
        win     = '0;
        win_any = 1'b0;
        win_rec = '0;
        for (int i = 0; i < NBR; i++) begin
            win[i] = cand[i];
            for (int j = 0; j < NBR; j++) begin
                if (j != i && cand[j]) begin
                    if (j < i) begin
                        if (!older[i][j]) win[i] = 1'b0;
                    end else if (older[j][i]) begin
                        win[i] = 1'b0;
                    end
                end
            end
        end
        for (int i = 0; i < NBR; i++) begin
            if (win[i]) begin
                win_any          = 1'b1;
                win_rec.pc       = br_dest[i];
                win_rec.addr     = br_addr[i];
                win_rec.is_short = br_short[i];
                win_rec.dec      = br_dec[i];
            end
        end
    end

    commit_age_cmp #(.N(NCOMMIT), .LN(LNCOMMIT)) u_held_cmp (
        .a       (win_rec.addr),
        .b       (hold.addr),
        .head    (commit_head),
        .a_older (win_older_held)
    );

    assign multi     = (cand & (cand - NBR'(1))) != '0;
    assign kill_held = commit_kill[hold.addr];
    // In PEND without ack, any winner or a kill means something is thrown away.
    assign drop_now  = multi | ((state == ST_PEND) & ~rd.redirect_ack & (kill_held | win_any));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            valid_q    <= 1'b0;
            hold       <= '0;
            drop_count <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        hold    <= win_rec;
                        state   <= ST_PEND;
                        valid_q <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (rd.redirect_ack || kill_held || (win_any && win_older_held)) begin
                        if (win_any) begin
                            hold <= win_rec;
                        end else begin
                            state   <= ST_IDLE;
                            valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
            if (drop_now && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end

    assign rd.redirect_valid = valid_q;
    assign rd.redirect_pc    = hold.pc;
    assign rd.redirect_addr  = hold.addr;
    assign rd.redirect_short = hold.is_short;
    assign rd.redirect_dec   = hold.dec;
endmodule
